mpc_config_ctrl: RTL



---
 rtl/mpc_config_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mpc_config_ctrl.sv
// mpc_config_ctrl
// ---------------
// Owns the chip-level configuration bus that steers every pad selector of the
// 2x2 multi-project array. A configuration change is sequenced
// break-before-make: pads are gated, the selector configuration switches while
// every macro is held in reset, the array settles, resets are released, and
// finally the pads are re-enabled. After reset the same SETTLE/ENABLE tail runs
// once so the array boots into DEFAULT_CFG cleanly.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   cfg_req_valid  configuration request valid
//   cfg_req_data   requested configuration (sampled only on the transfer edge)
//   cfg_req_ready  request can be accepted (IDLE and not locked)
//   cfg_lock       lock request; sets the sticky lock
//   configuration  drives all pad selectors
//   pad_oe_gate    1 = pad output enables pass through, 0 = forced off
//   macro_rst_n    per-macro active-low reset (all bits identical)
//   busy           a sequence is in progress
//   cfg_done       one-cycle pulse when a sequence (or no-op request) completes
//   cfg_err        sticky: an out-of-range request was accepted
//   locked         sticky lock state
module mpc_config_ctrl #(
  parameter int unsigned CFG_W         = 4,
  parameter int unsigned NUM_CFG       = 4,
  parameter int unsigned DEFAULT_CFG   = 0,
  parameter int unsigned NUM_MACROS    = 4,
  parameter int unsigned ISO_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_req_valid,
  input  logic [CFG_W-1:0]      cfg_req_data,
  output logic                  cfg_req_ready,
  input  logic                  cfg_lock,
  output logic [CFG_W-1:0]      configuration,
  output logic                  pad_oe_gate,
  output logic [NUM_MACROS-1:0] macro_rst_n,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic                  locked
);

  localparam int unsigned CNT_MAX = (ISO_CYCLES > SETTLE_CYCLES) ? ISO_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] ISO_LAST    = CNT_W'(ISO_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CFG_W-1:0] CFG_RESET   = CFG_W'(DEFAULT_CFG);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISOLATE = 2'd1,
    SETTLE  = 2'd2,
    ENABLE  = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [CFG_W-1:0]        pending, pending_nxt;

  logic [CFG_W-1:0]        configuration_nxt;
  logic                    pad_oe_gate_nxt;
  logic [NUM_MACROS-1:0]   macro_rst_n_nxt;
  logic                    busy_nxt;
  logic                    cfg_done_nxt;
  logic                    cfg_err_nxt;
  logic                    locked_nxt;

  logic                    xfer;
  logic                    req_legal;
  logic                    req_same;
  logic                    iso_last;
  logic                    settle_last;

  // Ready depends only on state and the registered lock, so a lock request on
  // the same edge as a transfer does not block that transfer.
  assign cfg_req_ready = (state == IDLE) && !locked;
  assign xfer          = cfg_req_valid && cfg_req_ready;
  assign req_legal     = 32'(cfg_req_data) < NUM_CFG;
  assign req_same      = (cfg_req_data == configuration);
  assign iso_last      = (cnt == ISO_LAST);
  assign settle_last   = (cnt == SETTLE_LAST);

  // State register: reset lands in SETTLE so boot runs the normal tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SETTLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; the counter restarts at 0 on every state change.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (xfer && req_legal && !req_same) state_nxt = ISOLATE;
      end
      ISOLATE: begin
        if (iso_last) state_nxt = SETTLE;
        else          cnt_nxt   = cnt + CNT_W'(1);
      end
      SETTLE: begin
        if (settle_last) state_nxt = ENABLE;
        else             cnt_nxt   = cnt + CNT_W'(1);
      end
      ENABLE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    configuration_nxt = configuration;
    pad_oe_gate_nxt   = pad_oe_gate;
    macro_rst_n_nxt   = macro_rst_n;
    busy_nxt          = busy;
    cfg_done_nxt      = 1'b0;
    cfg_err_nxt       = cfg_err;
    locked_nxt        = locked | cfg_lock;
    pending_nxt       = pending;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (!req_legal) begin
            cfg_err_nxt = 1'b1;
          end else if (req_same) begin
            cfg_done_nxt = 1'b1;
          end else begin
            pending_nxt     = cfg_req_data;
            pad_oe_gate_nxt = 1'b0;
            busy_nxt        = 1'b1;
          end
        end
      end
      ISOLATE: begin
        // Selector switches on the same edge the macros enter reset.
        if (iso_last) begin
          configuration_nxt = pending;
          macro_rst_n_nxt   = '0;
        end
      end
      SETTLE: begin
        if (settle_last) macro_rst_n_nxt = '1;
      end
      ENABLE: begin
        pad_oe_gate_nxt = 1'b1;
        busy_nxt        = 1'b0;
        cfg_done_nxt    = 1'b1;
      end
      default: begin
        busy_nxt = 1'b1;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      configuration <= CFG_RESET;
      pad_oe_gate   <= 1'b0;
      macro_rst_n   <= '0;
      busy          <= 1'b1;
      cfg_done      <= 1'b0;
      cfg_err       <= 1'b0;
      locked        <= 1'b0;
    end else begin
      configuration <= configuration_nxt;
      pad_oe_gate   <= pad_oe_gate_nxt;
      macro_rst_n   <= macro_rst_n_nxt;
      busy          <= busy_nxt;
      cfg_done      <= cfg_done_nxt;
      cfg_err       <= cfg_err_nxt;
      locked        <= locked_nxt;
    end
  end

  // Pending target is only consumed after a fresh latch in IDLE, so it needs
  // no reset value.
  always_ff @(posedge clk) begin
    pending <= pending_nxt;
  end

endmodule
